// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: FSM encodings, frame shape
// and the bit-period helper.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
    localparam logic [2:0] ST_PARITY = 3'd4;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Bit period in clock cycles, truncated.
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/tx_byte_fifo.sv
// Byte FIFO between producers and the UART serialiser: registered read data
// on pop, registered full/empty flags derived from the occupancy count.
module tx_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       fifo_full,
    output logic       fifo_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [AW:0]   count_next;
    logic          full_reg;
    logic          empty_reg;
    logic [7:0]    rd_data_reg;
    logic          push;
    logic          pop;

    // A write while full is dropped even if a pop happens on the same edge.
    assign push = wr_en && !full_reg;
    assign pop  = rd_en && !empty_reg;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
            full_reg  <= (count_next == (AW+1)'(DEPTH));
            empty_reg <= (count_next == '0);
        end
    end

    // Storage and read port kept reset-free so they map onto block RAM.
    always_ff @(posedge clk_50MHz) begin
        if (push) mem[wr_ptr_reg] <= wr_data;
        if (pop)  rd_data_reg <= mem[rd_ptr_reg];
    end

    assign rd_data    = rd_data_reg;
    assign fifo_full  = full_reg;
    assign fifo_empty = empty_reg;

endmodule

// File: rtl/uart_tx_stream.sv
// FIFO-fed 8N1 UART transmitter. Define UART_TX_PARITY_EN to insert an
// even-parity bit between the data bits and the stop bit.
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 9600,
    parameter int DEPTH  = 16
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);
    localparam int DIV = calc_div(CLK_HZ, BAUD);
    localparam int CW  = $clog2(DIV + 1);

    logic [2:0]    state_reg;
    logic [2:0]    state_next;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    bit_idx_reg;
    logic [7:0]    shift_reg;
    logic          tx_reg;
    logic          busy_reg;
    logic          done_reg;
    logic [7:0]    fifo_rd_data;
    logic          pop;
    logic          cnt_done;
`ifdef UART_TX_PARITY_EN
    logic          parity_reg;
`endif

    assign pop      = (state_reg == ST_IDLE) && !fifo_empty;
    assign cnt_done = (cnt_reg == CW'(DIV - 1));

    tx_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_50MHz  (clk_50MHz),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .rd_en      (pop),
        .rd_data    (fifo_rd_data),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (!fifo_empty) state_next = ST_START;
            ST_START: if (cnt_done) state_next = ST_DATA;
            ST_DATA:
                if (cnt_done && bit_idx_reg == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                    state_next = ST_PARITY;
`else
                    state_next = ST_STOP;
`endif
                end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: if (cnt_done) state_next = ST_STOP;
`endif
            ST_STOP:
                if (cnt_done && bit_idx_reg == 3'(STOP_BITS - 1)) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // tx, busy and tx_done are registered from the current state, so the
    // line trails the FSM by one cycle; busy is stretched to cover that cycle.
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;

            if (state_reg == ST_IDLE || cnt_done) cnt_reg <= '0;
            else                                   cnt_reg <= cnt_reg + 1'b1;

            if (state_next != state_reg) bit_idx_reg <= '0;
            else if (cnt_done)           bit_idx_reg <= bit_idx_reg + 1'b1;

            // Popped byte is valid from the first START cycle onwards.
            if (state_reg == ST_START)                  shift_reg <= fifo_rd_data;
            else if (state_reg == ST_DATA && cnt_done)  shift_reg <= {1'b0, shift_reg[7:1]};
`ifdef UART_TX_PARITY_EN
            if (state_reg == ST_START) parity_reg <= ^fifo_rd_data;
`endif

            case (state_reg)
                ST_START:  tx_reg <= 1'b0;
                ST_DATA:   tx_reg <= shift_reg[0];
`ifdef UART_TX_PARITY_EN
                ST_PARITY: tx_reg <= parity_reg;
`endif
                default:   tx_reg <= 1'b1;
            endcase

            busy_reg <= (state_reg != ST_IDLE) || (state_next != ST_IDLE);
            done_reg <= (state_reg == ST_STOP) && (state_next == ST_IDLE);
        end
    end

    assign tx      = tx_reg;
    assign busy    = busy_reg;
    assign tx_done = done_reg;

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: directed steps with random payloads, each frame
// compared bit-by-bit against bit patterns computed from the byte value.
module tb_uart_tx_stream;
    localparam int CLK_HZ = 165;
    localparam int BAUD   = 10;
    localparam int DEPTH  = 16;
    localparam int DIV    = 16;   // 165/10 = 16.5, truncated
`ifdef UART_TX_PARITY_EN
    localparam int NBITS  = 11;
`else
    localparam int NBITS  = 10;
`endif
    localparam int FRAME  = NBITS * DIV + 1;

    logic       clk_50MHz = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       fifo_full;
    logic       fifo_empty;
    logic       tx;
    logic       busy;
    logic       tx_done;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    int last_fall = 0;
    logic fall_empty;
    logic [7:0] exp_q[$];
    logic [7:0] round_bytes[10];

    uart_tx_stream #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
        .clk_50MHz  (clk_50MHz),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    always #5 clk_50MHz = ~clk_50MHz;
    always @(posedge clk_50MHz) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line level of frame bit k for byte b: start, LSB-first data, [parity], stop.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clk_50MHz);
        wr_en   = 1'b0;
    endtask

    task automatic wait_fall(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            if (tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_50MHz);
        end
        if (!ok) check("fall_timeout", 32'(tx), 32'd0);
    endtask

    task automatic check_frame(input logic [7:0] b, input bit chk_period);
        bit ok;
        logic exp;
        wait_fall(ok);
        if (!ok) return;
        fall_empty = fifo_empty;
        if (chk_period) check("frame_period", 32'(cyc - last_fall), 32'(FRAME));
        last_fall = cyc;
        for (int k = 0; k < NBITS; k++) begin
            exp = frame_bit(b, k);
            check($sformatf("byte%02h_bit%0d_first", b, k), 32'(tx), 32'(exp));
            check($sformatf("byte%02h_bit%0d_busy", b, k), 32'(busy), 32'd1);
            repeat (DIV - 1) @(negedge clk_50MHz);
            check($sformatf("byte%02h_bit%0d_last", b, k), 32'(tx), 32'(exp));
            check($sformatf("byte%02h_bit%0d_done", b, k), 32'(tx_done), 32'(k == NBITS - 1));
            @(negedge clk_50MHz);
        end
        check($sformatf("byte%02h_after_tx", b), 32'(tx), 32'd1);
        check($sformatf("byte%02h_after_done", b), 32'(tx_done), 32'd0);
        $display("frame byte=%02h checked at cycle %0d", b, cyc);
    endtask

    task automatic idle_check(input string tag, input int n);
        int lows = 0;
        repeat (n) begin
            @(negedge clk_50MHz);
            if (tx !== 1'b1) lows++;
        end
        check(tag, 32'(lows), 32'd0);
    endtask

    initial begin
        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        repeat (3) @(negedge clk_50MHz);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_empty", 32'(fifo_empty), 32'd1);
        check("rst_full", 32'(fifo_full), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk_50MHz);

        // Single byte with latency check.
        push(8'h31);
        check("lat_n_tx", 32'(tx), 32'd1);
        check("lat_n_empty", 32'(fifo_empty), 32'd0);
        @(negedge clk_50MHz);
        check("lat_n1_tx", 32'(tx), 32'd1);
        check("lat_n1_busy", 32'(busy), 32'd1);
        check("lat_n1_empty", 32'(fifo_empty), 32'd1);
        @(negedge clk_50MHz);
        check("lat_n2_tx", 32'(tx), 32'd0);
        check_frame(8'h31, 1'b0);
        check("single_busy_after", 32'(busy), 32'd0);
        idle_check("single_no_extra", FRAME);

        // Burst of 18 writes: one pops straight away, 16 fill the FIFO, 0x11 drops.
        fork
            begin
                for (int i = 0; i < 18; i++) begin
                    wr_en   = 1'b1;
                    wr_data = 8'(i);
                    @(negedge clk_50MHz);
                    if (i == 15) check("burst_full_w16", 32'(fifo_full), 32'd0);
                    if (i >= 16) check($sformatf("burst_full_w%0d", i + 1), 32'(fifo_full), 32'd1);
                end
                wr_en = 1'b0;
            end
            begin
                for (int f = 0; f < 17; f++) begin
                    check_frame(8'(f), f > 0);
                    if (f == 15) check("burst_empty_pop16", 32'(fall_empty), 32'd0);
                    if (f == 16) check("burst_empty_pop17", 32'(fall_empty), 32'd1);
                end
            end
        join
        check("burst_busy_end", 32'(busy), 32'd0);
        check("burst_full_end", 32'(fifo_full), 32'd0);
        idle_check("burst_dropped_byte", FRAME);

        // Three rounds of ten random bytes, crossing the pointer wrap.
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 10; j++) begin
                round_bytes[j] = 8'($urandom_range(0, 255));
                exp_q.push_back(round_bytes[j]);
            end
            fork
                begin
                    for (int j = 0; j < 10; j++) push(round_bytes[j]);
                end
                begin
                    for (int j = 0; j < 10; j++) check_frame(exp_q.pop_front(), j > 0);
                end
            join
            check($sformatf("round%0d_empty", r), 32'(fifo_empty), 32'd1);
            idle_check($sformatf("round%0d_idle", r), 4);
        end

        // Reset during data bit 4 of 0x55 with three bytes still queued.
        push(8'h55);
        push(8'hA1);
        push(8'hB2);
        push(8'hC3);
        repeat (5 * DIV - 2 + DIV / 2) @(negedge clk_50MHz);
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_empty", 32'(fifo_empty), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("arst_tx", 32'(tx), 32'd1);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_empty", 32'(fifo_empty), 32'd1);
        check("arst_full", 32'(fifo_full), 32'd0);
        check("arst_done", 32'(tx_done), 32'd0);
        repeat (2) @(negedge clk_50MHz);
        reset = 1'b1;
        idle_check("post_reset_no_frame", 2 * FRAME);
        check("post_reset_empty", 32'(fifo_empty), 32'd1);
        check("post_reset_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
